// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register of the 16-bit WISC pipeline: registers the ALU result and
// memory-stage controls, owns the Z/V/N flags, the sticky halt latch and the EX->EX forward source.
module ex_mem_pipe #(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          ex_valid,
  input  logic [3:0]    ex_opcode,
  input  logic [DW-1:0] ex_alu_out,
  input  logic          ex_ovfl,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_regwrite,
  input  logic          ex_memread,
  input  logic          ex_memwrite,
  input  logic [DW-1:0] ex_store_data,
  output logic          mem_valid,
  output logic [3:0]    mem_opcode,
  output logic [DW-1:0] mem_alu_out,
  output logic [RW-1:0] mem_rd,
  output logic          mem_regwrite,
  output logic          mem_memread,
  output logic          mem_memwrite,
  output logic [DW-1:0] mem_store_data,
  output logic          flag_z,
  output logic          flag_v,
  output logic          flag_n,
  output logic          fwd_valid,
  output logic [RW-1:0] fwd_rd,
  output logic [DW-1:0] fwd_data,
  output logic          halted
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  logic acc;
  logic upd;

  assign acc = ex_valid & ~flush & ~halted;
  assign upd = acc & ~stall;

  // Flush outranks stall; a non-accepted instruction still loads its data fields but as a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid      <= 1'b0;
      mem_opcode     <= '0;
      mem_alu_out    <= '0;
      mem_rd         <= '0;
      mem_regwrite   <= 1'b0;
      mem_memread    <= 1'b0;
      mem_memwrite   <= 1'b0;
      mem_store_data <= '0;
    end else if (flush) begin
      mem_valid      <= 1'b0;
      mem_opcode     <= '0;
      mem_alu_out    <= '0;
      mem_rd         <= '0;
      mem_regwrite   <= 1'b0;
      mem_memread    <= 1'b0;
      mem_memwrite   <= 1'b0;
      mem_store_data <= '0;
    end else if (!stall) begin
      mem_valid      <= acc;
      mem_opcode     <= ex_opcode;
      mem_alu_out    <= ex_alu_out;
      mem_rd         <= ex_rd;
      mem_regwrite   <= acc & ex_regwrite;
      mem_memread    <= acc & ex_memread;
      mem_memwrite   <= acc & ex_memwrite;
      mem_store_data <= ex_store_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_v <= 1'b0;
      flag_n <= 1'b0;
      halted <= 1'b0;
    end else if (upd) begin
      case (ex_opcode)
        OP_ADD, OP_SUB: begin
          flag_z <= (ex_alu_out == '0);
          flag_v <= ex_ovfl;
          flag_n <= ex_alu_out[DW-1];
        end
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: flag_z <= (ex_alu_out == '0);
        OP_HLT: halted <= 1'b1;
        default: ;
      endcase
    end
  end

  // Loads are never forwarded from here (data not yet read); r0 is hardwired zero.
  assign fwd_valid = mem_valid & mem_regwrite & ~mem_memread & (mem_rd != '0);
  assign fwd_rd    = mem_rd;
  assign fwd_data  = mem_alu_out;

endmodule
